// File: rtl/jtkiwi_shram_arb_pkg.sv
// Shared types for the kiwi shared-RAM arbiter.
package jtkiwi_shram_arb_pkg;

  // Arbiter FSM: IDLE picks a requester, ACC runs the RAM access.
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/jtkiwi_shram_port.sv
// Per-CPU side of the shared-RAM arbiter: done flag, wait request and
// registered read data.
module jtkiwi_shram_port #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          capture,   // capture cycle of an access owned by this CPU
  input  logic          rd,        // the owned access is a read
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic [DW-1:0] dout
);

  logic done;

  // Combinational so the CPU is held in the very cycle cs rises.
  assign busy = cs & ~done;

  // done holds off a re-grant while cs stays high; drops with cs.
  always_ff @(posedge clk) begin
    if (rst)          done <= 1'b0;
    else if (!cs)     done <= 1'b0;
    else if (capture) done <= 1'b1;
  end

  // Read data is kept until the next read of this CPU completes, even when
  // the CPU already let go of cs.
  always_ff @(posedge clk) begin
    if (rst)                dout <= '0;
    else if (capture && rd) dout <= ram_dout;
  end

endmodule

// File: rtl/jtkiwi_shram_arb.sv
// Arbiter serialising the main and sound Z80s onto the single-port shared
// RAM, with round-robin on simultaneous requests.
module jtkiwi_shram_arb
  import jtkiwi_shram_arb_pkg::*;
#(
  parameter int AW      = 13,
  parameter int DW      = 8,
  parameter int ACC_CYC = 2    // must be at least 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_cs,
  input  logic          main_rnw,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_din,
  output logic [DW-1:0] main_dout,
  output logic          main_busy,
  input  logic          snd_cs,
  input  logic          snd_rnw,
  input  logic [AW-1:0] snd_addr,
  input  logic [DW-1:0] snd_din,
  output logic [DW-1:0] snd_dout,
  output logic          snd_busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic          gnt_snd
);

  localparam int CW = $clog2(ACC_CYC + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last_snd;   // 1: sound won the previous grant
  logic          cur_rd;     // direction of the access in flight
  logic          grant, pick_snd, capture;

  // Next state and grant decision. cnt counts cycles since the grant edge;
  // the registered RAM output is valid once it reaches ACC_CYC.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pick_snd  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (main_busy || snd_busy) begin
          grant     = 1'b1;
          pick_snd  = snd_busy & (~main_busy | ~last_snd);
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (cnt == CW'(ACC_CYC)) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // RAM request registers, access counter and round-robin memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      cnt      <= '0;
      last_snd <= 1'b0;
      gnt_snd  <= 1'b0;
      cur_rd   <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (grant) begin
        ram_addr <= pick_snd ? snd_addr : main_addr;
        ram_din  <= pick_snd ? snd_din  : main_din;
        ram_we   <= pick_snd ? ~snd_rnw : ~main_rnw;
        cur_rd   <= pick_snd ?  snd_rnw :  main_rnw;
        cnt      <= CW'(1);
        gnt_snd  <= pick_snd;
        last_snd <= pick_snd;
      end else if (state == ACC) begin
        cnt <= cnt + CW'(1);
        if (capture) gnt_snd <= 1'b0;
      end
    end
  end

  jtkiwi_shram_port #(.DW(DW)) u_main (
    .clk      (clk),
    .rst      (rst),
    .cs       (main_cs),
    .capture  (capture & ~gnt_snd),
    .rd       (cur_rd),
    .ram_dout (ram_dout),
    .busy     (main_busy),
    .dout     (main_dout)
  );

  jtkiwi_shram_port #(.DW(DW)) u_snd (
    .clk      (clk),
    .rst      (rst),
    .cs       (snd_cs),
    .capture  (capture & gnt_snd),
    .rd       (cur_rd),
    .ram_dout (ram_dout),
    .busy     (snd_busy),
    .dout     (snd_dout)
  );

endmodule
